// File: rtl/alu_exec_pkg.sv
// Shared constants and types for the RV32IM execute stage: field widths,
// opcode/funct codes, reset/write-enable levels and the local FSM encoding.
package alu_exec_pkg;

    localparam int OPCODE_SIZE   = 7;
    localparam int FUNC3_SIZE    = 3;
    localparam int FUNC7_SIZE    = 7;
    localparam int REG_ADDR_SIZE = 5;

    localparam logic [OPCODE_SIZE-1:0] OP      = 7'b0110011;
    localparam logic [OPCODE_SIZE-1:0] OP_IMM  = 7'b0010011;
    localparam logic [OPCODE_SIZE-1:0] LUI     = 7'b0110111;
    localparam logic [OPCODE_SIZE-1:0] NOP     = 7'b0000000;

    localparam logic [FUNC7_SIZE-1:0] BASE_F7   = 7'b0000000;
    localparam logic [FUNC7_SIZE-1:0] ALT_F7    = 7'b0100000;
    localparam logic [FUNC7_SIZE-1:0] MULDIV_F7 = 7'b0000001;

    localparam logic [FUNC3_SIZE-1:0] F3_ADD  = 3'b000;
    localparam logic [FUNC3_SIZE-1:0] F3_SLL  = 3'b001;
    localparam logic [FUNC3_SIZE-1:0] F3_SLT  = 3'b010;
    localparam logic [FUNC3_SIZE-1:0] F3_SLTU = 3'b011;
    localparam logic [FUNC3_SIZE-1:0] F3_XOR  = 3'b100;
    localparam logic [FUNC3_SIZE-1:0] F3_SR   = 3'b101;
    localparam logic [FUNC3_SIZE-1:0] F3_OR   = 3'b110;
    localparam logic [FUNC3_SIZE-1:0] F3_AND  = 3'b111;

    // Reset is asserted when resetIn equals this level.
    localparam logic RESET_ACTIVE = 1'b0;
    localparam logic WRITE_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    // DIV/DIVU/REM/REMU: OP with the M-extension funct7 and funct3[2] set.
    function automatic logic is_divide(
        input logic [OPCODE_SIZE-1:0] opcode,
        input logic                   func3_msb,
        input logic [FUNC7_SIZE-1:0]  func7
    );
        return (opcode == OP) && (func7 == MULDIV_F7) && func3_msb;
    endfunction

endpackage

// File: rtl/alu_exec_divider.sv
// Iterative radix-2 restoring divider. Works on magnitudes and applies sign
// correction and the divide-by-zero result combinationally on the way out.
module alu_divider
    import alu_exec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DIV_ITER = 32
) (
    input  logic            clk,
    input  logic            resetIn,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            abort,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last,
    output logic            done
);

    localparam int CW = $clog2(DIV_ITER + 1);

    logic [CW-1:0]   count_reg;
    logic [XLEN-1:0] quot_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] divisor_reg;
    logic [XLEN-1:0] dividend_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic            div_zero_reg;
    logic            done_reg;

    logic [XLEN-1:0] dividend_mag;
    logic [XLEN-1:0] divisor_mag;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] diff_lo;

    // Operand magnitudes at start, and the trial subtraction of one step.
    always_comb begin
        dividend_mag = (is_signed && dividend[XLEN-1]) ? (~dividend + 1'b1) : dividend;
        divisor_mag  = (is_signed && divisor[XLEN-1])  ? (~divisor + 1'b1)  : divisor;
        shifted      = {rem_reg, quot_reg[XLEN-1]};
        fits         = (shifted >= {1'b0, divisor_reg});
        // The true difference is below the divisor, so the low word is exact.
        diff_lo      = shifted[XLEN-1:0] - divisor_reg;
    end

    // Load on start, then one shift-subtract step per cycle until the count runs out.
    always_ff @(posedge clk) begin
        if (resetIn == RESET_ACTIVE) begin
            count_reg    <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
            divisor_reg  <= '0;
            dividend_reg <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else if (abort) begin
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else if (start) begin
            count_reg    <= CW'(DIV_ITER);
            quot_reg     <= dividend_mag;
            rem_reg      <= '0;
            divisor_reg  <= divisor_mag;
            dividend_reg <= dividend;
            neg_q_reg    <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r_reg    <= is_signed && dividend[XLEN-1];
            div_zero_reg <= (divisor == '0);
            done_reg     <= 1'b0;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
            quot_reg  <= {quot_reg[XLEN-2:0], fits};
            rem_reg   <= fits ? diff_lo : shifted[XLEN-1:0];
            done_reg  <= (count_reg == CW'(1));
        end else begin
            done_reg <= 1'b0;
        end
    end

    // Sign fix-up; divide by zero overrides with all-ones / original dividend.
    // Signed overflow needs no special case: the negated magnitude wraps to itself.
    always_comb begin
        quotient  = div_zero_reg ? '1 : (neg_q_reg ? (~quot_reg + 1'b1) : quot_reg);
        remainder = div_zero_reg ? dividend_reg : (neg_r_reg ? (~rem_reg + 1'b1) : rem_reg);
    end

    assign last = (count_reg == CW'(1));
    assign done = done_reg;

endmodule

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU/LUI/MUL datapath, a divide sequencer around
// alu_divider, and the registered ALU/MEM boundary.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DIV_ITER = 32
) (
    input  logic                     clk,
    input  logic                     resetIn,
    input  logic                     flushIn,
    input  logic [XLEN-1:0]          dataAlu1,
    input  logic [XLEN-1:0]          dataAlu2,
    input  logic [XLEN-1:0]          immValueAlu,
    input  logic [OPCODE_SIZE-1:0]   ALUopcodeAlu,
    input  logic [FUNC3_SIZE-1:0]    ALUFunc3Alu,
    input  logic [FUNC7_SIZE-1:0]    ALUFunc7Alu,
    input  logic                     writeEnableAlu,
    input  logic [REG_ADDR_SIZE-1:0] writeBackAddrIn,
    output logic                     stallOut,
    output logic [XLEN-1:0]          aluResultMem,
    output logic                     writeEnableMem,
    output logic [REG_ADDR_SIZE-1:0] writeBackAddrMem
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e state_reg, state_next;

    logic [XLEN-1:0]          result_reg, result_next;
    logic                     we_reg, we_next;
    logic [REG_ADDR_SIZE-1:0] addr_reg, addr_next;

    // Write-back fields of the divide in flight.
    logic                     div_rem_reg;
    logic                     div_we_reg;
    logic [REG_ADDR_SIZE-1:0] div_rd_reg;

    logic is_op, is_imm, is_lui, is_md, is_div, valid_op, rd_we;
    logic [XLEN-1:0]   op_a, op_b, alu_res, mul_res, single_res;
    logic [SHW-1:0]    shamt;
    logic              a_sx, b_sx;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;

    logic            div_start, div_abort, div_last, div_done, stall;
    logic [XLEN-1:0] div_quot, div_rem;

    // Decode and operand selection.
    always_comb begin
        is_op    = (ALUopcodeAlu == OP);
        is_imm   = (ALUopcodeAlu == OP_IMM);
        is_lui   = (ALUopcodeAlu == LUI);
        is_md    = is_op && (ALUFunc7Alu == MULDIV_F7);
        is_div   = is_divide(ALUopcodeAlu, ALUFunc3Alu[2], ALUFunc7Alu);
        valid_op = is_imm || is_lui ||
                   (is_op && (ALUFunc7Alu == BASE_F7 || ALUFunc7Alu == ALT_F7 || is_md));
        rd_we    = (writeEnableAlu == WRITE_ENABLE) && (writeBackAddrIn != '0);
        op_a     = dataAlu1;
        op_b     = is_op ? dataAlu2 : immValueAlu;
        shamt    = op_b[SHW-1:0];
    end

    // RV32I integer operations; SUB only exists in the register form.
    always_comb begin
        alu_res = '0;
        case (ALUFunc3Alu)
            F3_ADD:  alu_res = (is_op && ALUFunc7Alu[5]) ? (op_a - op_b) : (op_a + op_b);
            F3_SLL:  alu_res = op_a << shamt;
            F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            F3_XOR:  alu_res = op_a ^ op_b;
            F3_SR:   alu_res = ALUFunc7Alu[5] ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
            F3_OR:   alu_res = op_a | op_b;
            F3_AND:  alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

    // Multiplier: extend operands per MULH/MULHSU/MULHU, keep the 2*XLEN product
    // modulo 2^(2*XLEN), which is exact for both halves.
    always_comb begin
        a_sx       = (ALUFunc3Alu[1:0] != 2'b11);
        b_sx       = (ALUFunc3Alu[1:0] == 2'b01);
        mul_a      = {{XLEN{a_sx & op_a[XLEN-1]}}, op_a};
        mul_b      = {{XLEN{b_sx & op_b[XLEN-1]}}, op_b};
        prod       = mul_a * mul_b;
        mul_res    = (ALUFunc3Alu[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        single_res = is_lui ? op_b : (is_md ? mul_res : alu_res);
    end

    alu_divider #(
        .XLEN     (XLEN),
        .DIV_ITER (DIV_ITER)
    ) u_divider (
        .clk       (clk),
        .resetIn   (resetIn),
        .start     (div_start),
        .is_signed (~ALUFunc3Alu[0]),
        .dividend  (op_a),
        .divisor   (op_b),
        .abort     (div_abort),
        .quotient  (div_quot),
        .remainder (div_rem),
        .last      (div_last),
        .done      (div_done)
    );

    // Next-state, divider control and next values of the output registers.
    always_comb begin
        state_next  = state_reg;
        result_next = '0;
        we_next     = 1'b0;
        addr_next   = '0;
        div_start   = 1'b0;
        div_abort   = 1'b0;
        stall       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!flushIn) begin
                    if (is_div) begin
                        div_start  = 1'b1;
                        stall      = 1'b1;
                        state_next = ST_BUSY;
                    end else if (valid_op) begin
                        result_next = single_res;
                        we_next     = rd_we;
                        addr_next   = writeBackAddrIn;
                    end
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (flushIn) begin
                    div_abort  = 1'b1;
                    state_next = ST_IDLE;
                end else if (div_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                if (flushIn) begin
                    div_abort = 1'b1;
                end else if (div_done) begin
                    result_next = div_rem_reg ? div_rem : div_quot;
                    we_next     = div_we_reg;
                    addr_next   = div_rd_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Upstream never sees a stall while reset is held.
    assign stallOut = (resetIn != RESET_ACTIVE) && stall;

    // State, held divide write-back fields and the ALU/MEM boundary registers.
    always_ff @(posedge clk) begin
        if (resetIn == RESET_ACTIVE) begin
            state_reg   <= ST_IDLE;
            result_reg  <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            div_rem_reg <= 1'b0;
            div_we_reg  <= 1'b0;
            div_rd_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            we_reg     <= we_next;
            addr_reg   <= addr_next;
            if (div_start) begin
                div_rem_reg <= ALUFunc3Alu[1];
                div_we_reg  <= rd_we;
                div_rd_reg  <= writeBackAddrIn;
            end
        end
    end

    assign aluResultMem     = result_reg;
    assign writeEnableMem   = we_reg;
    assign writeBackAddrMem = addr_reg;

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the RV32IM pipeline. Consumes the registered operands and control fields of the DEC/ALU pipeline register and computes the result:
- single-cycle for RV32I ALU ops, LUI and MUL*;
- a fixed-latency iterative radix-2 unit for DIV/DIVU/REM/REMU.

Results and write-back control go out on a registered ALU/MEM boundary. During a divide, `stallOut` freezes the DEC/ALU register and everything upstream of it.

## Interface
Parameters:
- `XLEN`, 32 — datapath width; equals the `DataSize` range in `define.v`.
- `DIV_ITER`, 32 — divider iterations; must equal `XLEN`.

Ports:
- `clk` in 1 — single clock; all state updates on posedge.
- `resetIn` in 1 — synchronous, active-low reset.
- `flushIn` in 1 — the DEC/ALU register's reset indicator, active-high. The current input is treated as a bubble and any divide in progress is aborted.
- `dataAlu1` in `DataSize` — rs1 value.
- `dataAlu2` in `DataSize` — rs2 value.
- `immValueAlu` in `DataSize` — sign-extended immediate; for LUI it is already shifted.
- `ALUopcodeAlu` in `OpcodeSize` — opcode; the `NOP` code marks a bubble.
- `ALUFunc3Alu` in `Func3Size` — funct3.
- `ALUFunc7Alu` in `Func7Size` — funct7.
- `writeEnableAlu` in 1 — write-back request.
- `writeBackAddrIn` in `RegAddrSize` — rd.
- `stallOut` out 1 — hold the upstream pipeline registers (combinational).
- `aluResultMem` out `DataSize` — registered result.
- `writeEnableMem` out 1 — registered write-back enable.
- `writeBackAddrMem` out `RegAddrSize` — registered rd.

## Operation
Operand B:
- `immValueAlu` for OP-IMM (0010011) and LUI (0110111).
- `dataAlu2` for OP (0110011).

Supported ops:
- ADD/SUB (SUB only for OP with funct7 0100000), SLL, SLT, SLTU, XOR, SRL/SRA (funct7 bit 5), OR, AND.
- LUI: result = imm.
- Shift amount is B[4:0].
- For OP with funct7 0000001:
  - funct3 0–3 (MUL, MULH, MULHSU, MULHU): single cycle, 64-bit product, low or high word per funct3.
  - funct3 4–7 (DIV, DIVU, REM, REMU): multi-cycle.

Divide rules:
- Signed ops divide magnitudes and fix the result signs afterwards.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Both special cases still take the full latency.

Output qualification:
- Any other opcode, `NOP`, or `flushIn`=1 yields a bubble: `writeEnableMem`=0, `aluResultMem`=0, addr=0.
- `writeEnableMem` = `writeEnableAlu` AND valid op AND rd≠0.

FSM:
- `IDLE`: if a divide is presented and `flushIn`=0, latch operands, funct3 and signs; counter = `DIV_ITER`; go to `BUSY`. Otherwise register the single-cycle result.
- `BUSY`: one shift-subtract step per cycle, counter decrements, outputs register a bubble. Counter reaching 1 → `DONE`.
- `DONE`: register the corrected quotient or remainder with the held rd and write enable; go to `IDLE`.

Stall and abort:
- `stallOut` = (`IDLE` AND divide presented AND NOT `flushIn`) OR `BUSY`.
- `stallOut` is 0 in `DONE`, which lets upstream advance past the held divide.
- `flushIn`=1 in `BUSY` or `DONE` → return to `IDLE` and register a bubble.

## Timing
Reset (`resetIn`=0 at a posedge):
- State → `IDLE`, counter → 0.
- `aluResultMem`=0, `writeEnableMem`=0, `writeBackAddrMem`=0.
- `stallOut` is forced to 0 while `resetIn`=0.
- Reset mid-divide discards the divide entirely.

Latency:
- Non-divide ops: 1 cycle (input in cycle n, output valid after edge n).
- Divide presented in cycle n: `BUSY` cycles n+1..n+32, `DONE` cycle n+33, result visible from cycle n+34.
- `stallOut` is high for cycles n..n+32 (33 cycles).

Back-to-back behaviour:
- A divide following a divide enters `BUSY` one cycle after `DONE`, with no lost instruction.
- The instruction after the divide is first sampled in the cycle after `DONE`.

## Structure
- Opcode, funct3 and funct7 codes (`OP`, `OP_IMM`, `LUI`, `MULDIV_F7`), `NOP`, and the reset and write-enable constants live in the shared `define.v`.
- The state encoding is local to this block.
- Sub-module `alu_divider`:
  - Ports: start, signed flag, operands, abort.
  - Produces quotient, remainder and a done flag, and owns the counter.
  - `alu_exec` keeps the FSM, the single-cycle datapath and the output registers.

## Test plan
- Reset: hold `resetIn`=0 for 2 cycles with ADD inputs present → all outputs 0, `stallOut`=0. Release → ADD 5+7 gives `aluResultMem`=12 one cycle later.
- SUB/SRA/SLTU:
  - SUB 3−5 → 0xFFFFFFFE.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLTU 1 < 0xFFFFFFFF → 1.
  - ADD with rd=0 → `writeEnableMem`=0.
- DIV -7/2 → quotient 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. Each with `stallOut` high for exactly 33 cycles and the result in cycle n+34.
- DIVU 10/0 → 0xFFFFFFFF. REM 0x80000000/0xFFFFFFFF → 0. Same latency.
- Abort:
  - `flushIn` pulsed at `BUSY` cycle 10 → bubble out, `IDLE` next cycle, `stallOut` low.
  - `resetIn` low mid-divide → outputs 0.
- Back-to-back DIVU 100/7 then ADD 1+1 → 14 then 2, with no duplicated or dropped write-back.
